vedic_iter_mult: RTL and testbench



---
 rtl/vedic_iter_mult.sv | 133 +++++++++++++
 tb/tb_vedic_iter_mult.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_iter_mult.sv
// Iterative WxW unsigned multiplier: a single 2x2 Vedic cell produces one digit-pair
// partial product per cycle, which is shifted and accumulated into a 2W-bit result.

module vedic_2_x_2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic t1, t2, c1, t3;

    assign t1   = a[1] & b[0];
    assign t2   = a[0] & b[1];
    assign c1   = t1 & t2;
    assign t3   = a[1] & b[1];
    assign p[0] = a[0] & b[0];
    assign p[1] = t1 ^ t2;
    assign p[2] = t3 ^ c1;
    assign p[3] = t3 & c1;
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one digit pair (i,j) multiplied and accumulated per cycle
// DONE  | finished product held on p until out_ready
module vedic_iter_mult #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);
    localparam int N  = W / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [2*W-1:0] acc_q, acc_d, p_q, p_d;
    logic [IW-1:0]  i_q, i_d, j_q, j_d;
    logic [1:0]     a_dig, b_dig;
    logic [3:0]     pp;
    logic [IW:0]    dig_sum;
    logic [2*W-1:0] pp_sh, acc_sum;

    assign a_dig = a_q[{i_q, 1'b0} +: 2];
    assign b_dig = b_q[{j_q, 1'b0} +: 2];

    vedic_2_x_2 u_cell (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    // Digit weight is 4^(i+j); the sum needs one extra bit before doubling.
    assign dig_sum = {1'b0, i_q} + {1'b0, j_q};
    assign pp_sh   = (2*W)'(pp) << {dig_sum, 1'b0};
    assign acc_sum = acc_q + pp_sh;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d     = '0;
                        p_d     = acc_sum;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = !in_ready;
    assign out_valid = (state_q == DONE);
    assign p         = p_q;
endmodule

// File: tb/tb_vedic_iter_mult.sv
// Scoreboard bench for vedic_iter_mult at W = 8, 2 and 16: directed cases on W = 8,
// latency probes on all widths, then concurrent random traffic with back-pressure.

module tb_vedic_iter_mult;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid_s  [NI];
    logic        in_ready_s  [NI];
    logic        out_valid_s [NI];
    logic        out_ready_s [NI];
    logic        busy_s      [NI];
    logic [15:0] a_s         [NI];
    logic [15:0] b_s         [NI];
    logic [31:0] p_s         [NI];
    logic [31:0] exp_q       [NI][$];
    int          wv          [NI] = '{8, 2, 16};
    bit          drv_done    [NI];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WW = (g == 0) ? 8 : (g == 1) ? 2 : 16;
        logic [2*WW-1:0] p_w;
        vedic_iter_mult #(.W(WW)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .a         (a_s[g][WW-1:0]),
            .b         (b_s[g][WW-1:0]),
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
            .p         (p_w),
            .busy      (busy_s[g])
        );
        assign p_s[g] = 32'(p_w);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: got timeout, required handshake within cycle budget", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b, input int budget);
        int cnt = 0;
        a_s[k] = a;
        b_s[k] = b;
        in_valid_s[k] = 1'b1;
        while (!in_ready_s[k] && cnt < budget) begin
            tick();
            cnt++;
        end
        if (!in_ready_s[k]) begin
            fail_now($sformatf("accept_w%0d", wv[k]));
            in_valid_s[k] = 1'b0;
            return;
        end
        exp_q[k].push_back(32'(longint'(a) * longint'(b)));
        tick();
        in_valid_s[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input int budget, output int lat);
        lat = 0;
        while (!out_valid_s[k] && lat < budget) begin
            tick();
            lat++;
        end
        if (!out_valid_s[k]) fail_now($sformatf("out_valid_w%0d", wv[k]));
    endtask

    task automatic wait_idle(input int k, input int budget);
        int cnt = 0;
        while (!in_ready_s[k] && cnt < budget) begin
            tick();
            cnt++;
        end
        if (!in_ready_s[k]) fail_now($sformatf("return_idle_w%0d", wv[k]));
    endtask

    task automatic rand_drive(input int k, input int n);
        logic [15:0] m;
        m = 16'((32'd1 << wv[k]) - 1);
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) tick();
            issue(k, 16'($urandom) & m, 16'($urandom) & m, 500);
        end
        drv_done[k] = 1'b1;
    endtask

    task automatic rand_bp(input int k);
        int cnt = 0;
        while ((!drv_done[k] || exp_q[k].size() != 0) && cnt < 60000) begin
            out_ready_s[k] = ($urandom_range(0, 3) != 0);
            tick();
            cnt++;
        end
        if (cnt >= 60000) fail_now($sformatf("drain_w%0d", wv[k]));
        out_ready_s[k] = 1'b1;
    endtask

    initial begin
        int lat;
        for (int k = 0; k < NI; k++) begin
            in_valid_s[k]  = 1'b0;
            out_ready_s[k] = 1'b0;
            a_s[k]         = '0;
            b_s[k]         = '0;
            drv_done[k]    = 1'b0;
        end

        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < NI; k++) begin
                    if (rst_n && out_valid_s[k] && out_ready_s[k]) begin
                        if (exp_q[k].size() == 0)
                            fail_now($sformatf("unexpected_output_w%0d", wv[k]));
                        else
                            check($sformatf("product_w%0d", wv[k]), p_s[k], exp_q[k].pop_front());
                    end
                end
            end
        join_none

        #12;
        check("reset_in_ready", 32'(in_ready_s[0]), 1);
        check("reset_out_valid", 32'(out_valid_s[0]), 0);
        check("reset_busy", 32'(busy_s[0]), 0);
        check("reset_p", p_s[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // basic product and latency
        out_ready_s[0] = 1'b1;
        issue(0, 16'd13, 16'd11, 50);
        wait_out(0, 100, lat);
        check("latency_w8", 32'(lat), 16);
        tick();
        check("in_ready_after_pop", 32'(in_ready_s[0]), 1);

        issue(0, 16'd255, 16'd255, 50);
        wait_idle(0, 100);
        issue(0, 16'd0, 16'd200, 50);
        wait_idle(0, 100);

        // back-pressure with competing operands
        out_ready_s[0] = 1'b0;
        issue(0, 16'd13, 16'd11, 50);
        wait_out(0, 100, lat);
        a_s[0] = 16'd7;
        b_s[0] = 16'd9;
        in_valid_s[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_p_stable", p_s[0], 143);
            check("bp_in_ready", 32'(in_ready_s[0]), 0);
            tick();
        end
        in_valid_s[0] = 1'b0;
        out_ready_s[0] = 1'b1;
        wait_idle(0, 100);

        // operands wiggle throughout RUN
        issue(0, 16'd200, 16'd77, 50);
        for (int c = 0; c < 15; c++) begin
            a_s[0] = 16'($urandom) & 16'hFF;
            b_s[0] = 16'($urandom) & 16'hFF;
            in_valid_s[0] = 1'b1;
            tick();
        end
        in_valid_s[0] = 1'b0;
        wait_idle(0, 100);

        // asynchronous reset in the 7th RUN cycle
        issue(0, 16'd100, 16'd100, 50);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 32'(out_valid_s[0]), 0);
        check("midrun_rst_p", p_s[0], 0);
        check("midrun_rst_in_ready", 32'(in_ready_s[0]), 1);
        check("midrun_rst_busy", 32'(busy_s[0]), 0);
        exp_q[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        issue(0, 16'd37, 16'd91, 50);
        wait_idle(0, 100);

        // latency at the width extremes
        out_ready_s[1] = 1'b1;
        issue(1, 16'd3, 16'd2, 50);
        wait_out(1, 100, lat);
        check("latency_w2", 32'(lat), 1);
        wait_idle(1, 100);
        out_ready_s[2] = 1'b1;
        issue(2, 16'hFFFF, 16'hFFFF, 50);
        wait_out(2, 200, lat);
        check("latency_w16", 32'(lat), 64);
        wait_idle(2, 200);

        fork
            rand_drive(0, 1000);
            rand_drive(1, 300);
            rand_drive(2, 300);
            rand_bp(0);
            rand_bp(1);
            rand_bp(2);
        join

        repeat (3) tick();
        for (int k = 0; k < NI; k++)
            check($sformatf("queue_left_w%0d", wv[k]), 32'(exp_q[k].size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
